bus_target_responder: RTL and testbench
=======================================

// Module: bus_target_responder
// PURPOSE
//   Target/responder end of the PE shared-bus protocol. Sits behind the
//   arbiter and serves one granted transaction at a time: global-memory
//   read/write (mem_ackBus + memData) and local register-file read/write
//   (data_ReadyBus + AmuxBus/BmuxBus). Emits single-cycle completion pulses
//   back to the PE-side bus interface.
// PARAMETERS
//   MEM_WORDS  1024  global memory depth in 32-bit words (power of two)
//   MEM_LAT    2     edges from command capture to mem_ackBus (>=1)
//   REG_LAT    1     edges from command capture to data_ReadyBus (fixed 1)
// PORTS
//   clk             in   1   clock, rising edge
//   reset           in   1   asynchronous, active-high
//   mem_addressBus  in   32  byte address for global memory
//   result_outBus   in   32  write data (memory or rd)
//   PCoutBus        in   32  PC of requesting PE; captured, unused internally
//   rs1OutBus       in   5   register-file read index A
//   rs2OutBus       in   5   register-file read index B
//   rdOutBus        in   5   register-file write index
//   reg_selectBus   in   1   0: read rs1 only, 1: read rs1 and rs2
//   mem_readBus     in   1   global memory read strobe
//   mem_writeBus    in   1   global memory write strobe
//   rd_writeBus     in   1   register-file write strobe
//   read_enBus      in   1   register-file read strobe
//   AmuxBus         out  32  register read data A
//   BmuxBus         out  32  register read data B
//   memData         out  32  memory read data
//   mem_ackBus      out  1   memory op complete, 1-cycle pulse
//   data_ReadyBus   out  1   register op complete, 1-cycle pulse
//   busy            out  1   transaction in flight; new strobes ignored
//   addr_err        out  1   1-cycle pulse with mem_ackBus on bad address
// BEHAVIOUR
//   Reset: all outputs 0, FSM IDLE, latency counter 0, register file x0..x31 = 0.
//     Memory array is not reset. Reset mid-transaction aborts it: no pulse, no write.
//   FSM states: IDLE, EXEC, MEM_WAIT, RESP.
//   IDLE: any strobe high at an edge -> capture all inputs, busy=1, go EXEC.
//   EXEC (1 cycle): rd_write applied first, then read_en sampled (write-first,
//     so a read of rd in the same command returns the new value). If a reg op is
//     present, data_ReadyBus=1 on the next cycle. If no mem op -> IDLE.
//     If mem op and MEM_LAT==1 -> RESP, else MEM_WAIT with counter=MEM_LAT-1.
//   MEM_WAIT: counter decrements each cycle; at counter 1 -> RESP.
//   RESP: perform memory access, pulse mem_ackBus for 1 cycle, busy=0 on exit -> IDLE.
//   Latency: reg result valid MEM_LAT-independent, REG_LAT=1 edge after capture.
//     Memory ack is asserted MEM_LAT edges after capture.
//   Register file: x0 reads 0, writes to x0 discarded. reg_selectBus=0 -> BmuxBus=0.
//   Memory: word index = mem_addressBus[log2(MEM_WORDS)+1:2].
//     Error if addr[1:0]!=0 or addr >= 4*MEM_WORDS -> no array access, memData=0,
//     addr_err pulses with mem_ackBus.
//   mem_read and mem_write both set: write performed, memData returns written value.
//   AmuxBus/BmuxBus/memData hold last value until overwritten by a later response.
//   Strobes during busy=1 are ignored (not queued); the initiator must wait for ack/ready.
//   Back-to-back: a strobe at the edge leaving RESP/EXEC->IDLE is not captured;
//     capture occurs at the first edge with state IDLE.
// TESTING
//   1. rd_write rd=5 data=0xDEADBEEF, then read_en rs1=5 rs2=0 sel=1
//      -> AmuxBus=0xDEADBEEF, BmuxBus=0, data_ReadyBus 1 cycle, 1 edge after capture.
//   2. mem_write addr=0x10 data=0x1234_5678, then mem_read addr=0x10 (MEM_LAT=2)
//      -> memData=0x12345678, mem_ackBus pulse exactly 2 edges after capture.
//   3. rd_write x0=0xFFFF_FFFF, then read_en rs1=0 -> AmuxBus=0.
//   4. mem_read addr=0x2 and addr=4*MEM_WORDS -> mem_ackBus=1, addr_err=1, memData=0, memory unchanged.
//   5. Combined rd_write rd=7 val=9 + read_en rs1=7 + mem_read addr=0x10
//      -> data_ReadyBus at +1 with AmuxBus=9; mem_ackBus at +MEM_LAT; second strobe while busy ignored.
//   6. Assert reset in MEM_WAIT of a mem_write -> no ack, all outputs 0, target word unchanged.

Source files
------------

// File: rtl/bus_target_responder.sv
// rtl/bus_target_responder.sv - PE shared-bus target: register file and global memory responder
module bus_target_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int MEM_LAT   = 2,
    parameter int REG_LAT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addressBus,
    input  logic [31:0] result_outBus,
    input  logic [31:0] PCoutBus,
    input  logic [4:0]  rs1OutBus,
    input  logic [4:0]  rs2OutBus,
    input  logic [4:0]  rdOutBus,
    input  logic        reg_selectBus,
    input  logic        mem_readBus,
    input  logic        mem_writeBus,
    input  logic        rd_writeBus,
    input  logic        read_enBus,
    output logic [31:0] AmuxBus,
    output logic [31:0] BmuxBus,
    output logic [31:0] memData,
    output logic        mem_ackBus,
    output logic        data_ReadyBus,
    output logic        busy,
    output logic        addr_err
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(4 * MEM_WORDS);
    localparam logic [7:0]  LAT_LOAD  = 8'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MEM_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic        w_capture;
    logic        w_do_reg;
    logic        w_do_mem;
    logic        w_any_strobe;

    // Captured command
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic        r_sel;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic        r_rd_we;
    logic        r_rd_en;

    logic [31:0] r_rf  [32];
    logic [31:0] r_mem [MEM_WORDS];

    logic          w_addr_ok;
    logic [AW-1:0] w_word;
    logic [31:0]   w_rd_a;
    logic [31:0]   w_rd_b;
    logic          w_unused_ok;

    assign w_any_strobe = mem_readBus | mem_writeBus | rd_writeBus | read_enBus;
    assign busy         = (r_state != S_IDLE);

    // The PC is carried with the command but has no internal consumer; REG_LAT is fixed at 1
    assign w_unused_ok  = (^r_pc) ^ (REG_LAT == 1);

    // Misaligned or out-of-range addresses never touch the array
    assign w_addr_ok = (r_addr[1:0] == 2'b00) && ({1'b0, r_addr} < MEM_BYTES);
    assign w_word    = r_addr[AW+1:2];

    // Write-first read ports: a same-command write to rd is visible to the read
    assign w_rd_a = (r_rd_we && (r_rd != 5'd0) && (r_rd == r_rs1)) ? r_wdata : r_rf[r_rs1];
    assign w_rd_b = (r_rd_we && (r_rd != 5'd0) && (r_rd == r_rs2)) ? r_wdata : r_rf[r_rs2];

    // FSM state and latency counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state; memory access and ack are registered on the edge that enters RESP
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_capture  = 1'b0;
        w_do_reg   = 1'b0;
        w_do_mem   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_strobe) begin
                    w_capture = 1'b1;
                    w_next    = S_EXEC;
                end
            end
            S_EXEC: begin
                w_do_reg = r_rd_we | r_rd_en;
                if (r_mem_rd | r_mem_wr) begin
                    if (MEM_LAT == 1) begin
                        w_do_mem = 1'b1;
                        w_next   = S_RESP;
                    end else begin
                        w_cnt_next = LAT_LOAD;
                        w_next     = S_MEM_WAIT;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_MEM_WAIT: begin
                if (r_cnt == 8'd1) begin
                    w_do_mem   = 1'b1;
                    w_cnt_next = 8'd0;
                    w_next     = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Capture the whole command at the accepting edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_pc     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_sel    <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_rd_we  <= 1'b0;
            r_rd_en  <= 1'b0;
        end else if (w_capture) begin
            r_addr   <= mem_addressBus;
            r_wdata  <= result_outBus;
            r_pc     <= PCoutBus;
            r_rs1    <= rs1OutBus;
            r_rs2    <= rs2OutBus;
            r_rd     <= rdOutBus;
            r_sel    <= reg_selectBus;
            r_mem_rd <= mem_readBus;
            r_mem_wr <= mem_writeBus;
            r_rd_we  <= rd_writeBus;
            r_rd_en  <= read_enBus;
        end
    end

    // Register file update and read response; x0 is never written so it reads 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= '0;
            end
            AmuxBus       <= '0;
            BmuxBus       <= '0;
            data_ReadyBus <= 1'b0;
        end else begin
            data_ReadyBus <= w_do_reg;
            if (w_do_reg && r_rd_we && (r_rd != 5'd0)) begin
                r_rf[r_rd] <= r_wdata;
            end
            if (w_do_reg && r_rd_en) begin
                AmuxBus <= w_rd_a;
                BmuxBus <= r_sel ? w_rd_b : 32'd0;
            end
        end
    end

    // Global memory array, intentionally not reset
    always_ff @(posedge clk) begin
        if (w_do_mem && r_mem_wr && w_addr_ok) begin
            r_mem[w_word] <= r_wdata;
        end
    end

    // Memory response; a combined read+write returns the written value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memData    <= '0;
            mem_ackBus <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            mem_ackBus <= w_do_mem;
            addr_err   <= w_do_mem & ~w_addr_ok;
            if (w_do_mem) begin
                if (!w_addr_ok) begin
                    memData <= 32'd0;
                end else if (r_mem_wr) begin
                    memData <= r_wdata;
                end else begin
                    memData <= r_mem[w_word];
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_target_responder.sv
// tb/tb_bus_target_responder.sv - scoreboard bench for bus_target_responder
module tb_bus_target_responder;

    localparam int MEM_WORDS = 1024;
    localparam int MEM_LAT   = 2;
    localparam int N_WORDS   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addressBus;
    logic [31:0] result_outBus;
    logic [31:0] PCoutBus;
    logic [4:0]  rs1OutBus;
    logic [4:0]  rs2OutBus;
    logic [4:0]  rdOutBus;
    logic        reg_selectBus;
    logic        mem_readBus;
    logic        mem_writeBus;
    logic        rd_writeBus;
    logic        read_enBus;
    logic [31:0] AmuxBus;
    logic [31:0] BmuxBus;
    logic [31:0] memData;
    logic        mem_ackBus;
    logic        data_ReadyBus;
    logic        busy;
    logic        addr_err;

    bus_target_responder #(
        .MEM_WORDS(MEM_WORDS),
        .MEM_LAT  (MEM_LAT),
        .REG_LAT  (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_addressBus(mem_addressBus),
        .result_outBus (result_outBus),
        .PCoutBus      (PCoutBus),
        .rs1OutBus     (rs1OutBus),
        .rs2OutBus     (rs2OutBus),
        .rdOutBus      (rdOutBus),
        .reg_selectBus (reg_selectBus),
        .mem_readBus   (mem_readBus),
        .mem_writeBus  (mem_writeBus),
        .rd_writeBus   (rd_writeBus),
        .read_enBus    (read_enBus),
        .AmuxBus       (AmuxBus),
        .BmuxBus       (BmuxBus),
        .memData       (memData),
        .mem_ackBus    (mem_ackBus),
        .data_ReadyBus (data_ReadyBus),
        .busy          (busy),
        .addr_err      (addr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } reg_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        logic        err;
    } mem_exp_t;

    reg_exp_t reg_q[$];
    mem_exp_t mem_q[$];

    // Reference state
    logic [31:0] m_rf [32];
    logic [31:0] m_mem [int];
    logic [31:0] m_a;
    logic [31:0] m_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every response pulse against the head of its queue
    always @(negedge clk) begin
        if (!reset) begin
            if (data_ReadyBus) begin
                if (reg_q.size() == 0) begin
                    check("ready_unexpected", 32'd1, 32'd0);
                end else begin
                    reg_exp_t e;
                    e = reg_q.pop_front();
                    check("ready_latency", cyc, e.cyc);
                    check("AmuxBus", AmuxBus, e.a);
                    check("BmuxBus", BmuxBus, e.b);
                end
            end
            if (mem_ackBus) begin
                if (mem_q.size() == 0) begin
                    check("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    mem_exp_t e;
                    e = mem_q.pop_front();
                    check("ack_latency", cyc, e.cyc);
                    check("memData", memData, e.d);
                    check("addr_err", {31'd0, addr_err}, {31'd0, e.err});
                end
            end else if (addr_err) begin
                check("addr_err_without_ack", 32'd1, 32'd0);
            end
        end
    end

    task automatic clear_strobes();
        mem_readBus  = 1'b0;
        mem_writeBus = 1'b0;
        rd_writeBus  = 1'b0;
        read_enBus   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_a = 32'd0;
        m_b = 32'd0;
    endtask

    // Issue one command when idle, predict its responses, optionally strobe again while busy
    task automatic issue(input logic mr, input logic mw, input logic rw, input logic re,
                         input logic sel, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] data,
                         input bit noise);
        int          cap;
        logic        has_reg;
        logic        has_mem;
        logic        err;
        logic [31:0] d;
        wait_idle();
        mem_readBus    = mr;
        mem_writeBus   = mw;
        rd_writeBus    = rw;
        read_enBus     = re;
        reg_selectBus  = sel;
        rs1OutBus      = rs1;
        rs2OutBus      = rs2;
        rdOutBus       = rd;
        mem_addressBus = addr;
        result_outBus  = data;
        PCoutBus       = $urandom;

        has_reg = rw | re;
        has_mem = mr | mw;
        if (rw && rd != 5'd0) m_rf[rd] = data;
        if (re) begin
            m_a = m_rf[rs1];
            m_b = sel ? m_rf[rs2] : 32'd0;
        end
        err = (addr % 4 != 0) || (addr >= 4 * MEM_WORDS);
        d   = 32'd0;
        if (has_mem && !err) begin
            if (mw) begin
                m_mem[int'(addr / 4)] = data;
                d = data;
            end else begin
                d = m_mem.exists(int'(addr / 4)) ? m_mem[int'(addr / 4)] : 32'd0;
            end
        end

        @(posedge clk);
        #1;
        cap = cyc;
        if (has_reg) reg_q.push_back('{cap + 1, m_a, m_b});
        if (has_mem) mem_q.push_back('{cap + MEM_LAT, d, err});
        clear_strobes();

        if (noise) begin
            @(negedge clk);
            mem_writeBus   = 1'b1;
            rd_writeBus    = 1'b1;
            read_enBus     = 1'($urandom_range(0, 1));
            mem_addressBus = 32'($urandom_range(0, N_WORDS - 1) * 4);
            result_outBus  = $urandom;
            rdOutBus       = 5'($urandom_range(1, 31));
            @(negedge clk);
            clear_strobes();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_AmuxBus"}, AmuxBus, 32'd0);
        check({tag, "_BmuxBus"}, BmuxBus, 32'd0);
        check({tag, "_memData"}, memData, 32'd0);
        check({tag, "_mem_ackBus"}, {31'd0, mem_ackBus}, 32'd0);
        check({tag, "_data_ReadyBus"}, {31'd0, data_ReadyBus}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_addr_err"}, {31'd0, addr_err}, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 5))
            0:       a = 32'($urandom_range(0, N_WORDS - 1) * 4) | 32'($urandom_range(1, 3));
            1:       a = 32'(4 * MEM_WORDS) + 32'($urandom_range(0, 255) * 4);
            default: a = 32'($urandom_range(0, N_WORDS - 1) * 4);
        endcase
        return a;
    endfunction

    initial begin
        reset = 1'b1;
        clear_strobes();
        reg_selectBus  = 1'b0;
        rs1OutBus      = '0;
        rs2OutBus      = '0;
        rdOutBus       = '0;
        mem_addressBus = '0;
        result_outBus  = '0;
        PCoutBus       = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;

        // Give every word used below a known value
        for (int w = 0; w < N_WORDS; w++)
            issue(0, 1, 0, 0, 0, 0, 0, 0, 32'(w * 4), $urandom, 0);

        // Register write then read with x0 on port B
        issue(0, 0, 1, 0, 0, 0, 0, 5, 32'd0, 32'hDEADBEEF, 0);
        issue(0, 0, 0, 1, 1, 5, 0, 0, 32'd0, 32'd0, 0);
        // Memory write then read back
        issue(0, 1, 0, 0, 0, 0, 0, 0, 32'h10, 32'h12345678, 0);
        issue(1, 0, 0, 0, 0, 0, 0, 0, 32'h10, 32'd0, 0);
        // x0 writes discarded
        issue(0, 0, 1, 0, 0, 0, 0, 0, 32'd0, 32'hFFFFFFFF, 0);
        issue(0, 0, 0, 1, 0, 0, 0, 0, 32'd0, 32'd0, 0);
        // Bad addresses, including a write that would alias word 0
        issue(1, 0, 0, 0, 0, 0, 0, 0, 32'h2, 32'd0, 0);
        issue(1, 0, 0, 0, 0, 0, 0, 0, 32'(4 * MEM_WORDS), 32'd0, 0);
        issue(0, 1, 0, 0, 0, 0, 0, 0, 32'h2, 32'hBAD0BAD0, 0);
        issue(0, 1, 0, 0, 0, 0, 0, 0, 32'(4 * MEM_WORDS), 32'hBAD1BAD1, 0);
        issue(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'd0, 0);
        // Combined register and memory command, with a strobe while busy
        issue(1, 0, 1, 1, 0, 7, 0, 7, 32'h10, 32'd9, 1);
        // Combined read+write of memory returns the written value
        issue(1, 1, 0, 0, 0, 0, 0, 0, 32'h20, 32'hA5A5_0F0F, 0);

        // Reset while a memory write is waiting
        wait_idle();
        mem_writeBus   = 1'b1;
        mem_addressBus = 32'h14;
        result_outBus  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        clear_strobes();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_outputs_zero("abort");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        issue(1, 0, 0, 0, 0, 0, 0, 0, 32'h14, 32'd0, 0);
        issue(0, 0, 0, 1, 1, 5, 7, 0, 32'd0, 32'd0, 0);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            logic [3:0] s;
            s = 4'($urandom_range(1, 15));
            issue(s[0], s[1], s[2], s[3], 1'($urandom_range(0, 1)),
                  5'($urandom), 5'($urandom), 5'($urandom),
                  rand_addr(), $urandom, ($urandom_range(0, 3) == 0));
        end

        begin
            int n;
            n = 0;
            while ((reg_q.size() != 0 || mem_q.size() != 0) && n < 20) begin
                @(negedge clk);
                n++;
            end
            repeat (4) @(negedge clk);
            check("reg_q_drained", reg_q.size(), 32'd0);
            check("mem_q_drained", mem_q.size(), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
